// File: rtl/sig_capture.sv
`default_nettype none
// ============================================================================
// sig_capture : single-shot capture of 2^A_WIDTH samples after a rising
//               threshold crossing, with a registered readback port.
// Rev 1.0
// ============================================================================
module sig_capture #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din,
  input  logic               arm,
  input  logic [D_WIDTH-1:0] thresh,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_armed   = 2'd1;
  localparam logic [1:0] c_st_capture = 2'd2;
  localparam logic [1:0] c_st_done    = 2'd3;

  localparam int                 c_depth     = 1 << A_WIDTH;
  localparam logic [A_WIDTH-1:0] c_addr_one  = A_WIDTH'(1);
  localparam logic [A_WIDTH-1:0] c_addr_last = {A_WIDTH{1'b1}};

  logic [1:0]         state_q, state_d;
  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [D_WIDTH-1:0] prev_q, prev_d;
  logic               prev_valid_q, prev_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [D_WIDTH-1:0] rd_data_q;

  logic               w_trig;
  logic               w_we;
  logic [A_WIDTH-1:0] w_waddr;

  logic [D_WIDTH-1:0] mem [c_depth];

  // State register plus the control/datapath flops it owns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= c_st_idle;
      wr_ptr_q     <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_data_q    <= mem[rd_addr];
    end
  end

  // Next-state logic; a crossing needs a real previous sample below thresh.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    w_we         = 1'b0;
    w_waddr      = wr_ptr_q;
    w_trig       = prev_valid_q && (prev_q < thresh) && (din >= thresh);

    case (state_q)
      c_st_idle, c_st_done: begin
        if (arm) begin
          state_d      = c_st_armed;
          wr_ptr_d     = '0;
          prev_valid_d = 1'b0;
        end
      end
      c_st_armed: begin
        if (en) begin
          prev_d       = din;
          prev_valid_d = 1'b1;
          if (w_trig) begin
            w_we     = 1'b1;
            w_waddr  = '0;
            wr_ptr_d = c_addr_one;
            state_d  = c_st_capture;
          end
        end
      end
      c_st_capture: begin
        if (en) begin
          w_we     = 1'b1;
          wr_ptr_d = wr_ptr_q + c_addr_one;
          if (wr_ptr_q == c_addr_last) begin
            state_d = c_st_done;
          end
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  // Status flags are decoded from the next state so they register with it.
  always_comb begin
    busy_d = (state_d == c_st_armed) || (state_d == c_st_capture);
    done_d = (state_d == c_st_done);
  end

  // Capture RAM has no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (w_we) begin
      mem[w_waddr] <= din;
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sig_capture.sv
`default_nettype none
// ============================================================================
// tb_sig_capture : directed stimulus with a queue-based scoreboard for
//                  sig_capture (A_WIDTH=8, D_WIDTH=8).
// Rev 1.0
// ============================================================================
module tb_sig_capture;

  localparam int A_WIDTH = 8;
  localparam int D_WIDTH = 8;

  logic                 clk    = 1'b0;
  logic                 rst    = 1'b1;
  logic                 en     = 1'b0;
  logic                 arm    = 1'b0;
  logic [D_WIDTH-1:0]   din    = '0;
  logic [D_WIDTH-1:0]   thresh = 8'h80;
  logic [A_WIDTH-1:0]   rd_addr = '0;
  logic [D_WIDTH-1:0]   rd_data;
  logic                 busy;
  logic                 done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         sb_due[$];
  int         sb_kind[$];
  logic [7:0] sb_exp[$];
  string      sb_name[$];

  logic [7:0] sine [256];

  sig_capture #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .din     (din),
    .arm     (arm),
    .thresh  (thresh),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops every expectation that falls due in this cycle.
  always @(negedge clk) begin : monitor
    int         m_kind;
    logic [7:0] m_exp;
    string      m_name;
    while (sb_due.size() > 0 && sb_due[0] <= cyc) begin
      void'(sb_due.pop_front());
      m_kind = sb_kind.pop_front();
      m_exp  = sb_exp.pop_front();
      m_name = sb_name.pop_front();
      case (m_kind)
        0:       chk(m_name, rd_data, m_exp);
        1:       chk(m_name, {7'b0, busy}, m_exp);
        default: chk(m_name, {7'b0, done}, m_exp);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [7:0] d);
    en  = e;
    din = d;
  endtask

  task automatic expect_st(input logic b, input logic d, input string name);
    sb_due.push_back(cyc + 1); sb_kind.push_back(1);
    sb_exp.push_back({7'b0, b}); sb_name.push_back({name, "_busy"});
    sb_due.push_back(cyc + 1); sb_kind.push_back(2);
    sb_exp.push_back({7'b0, d}); sb_name.push_back({name, "_done"});
  endtask

  task automatic expect_rd(input logic [7:0] a, input logic [7:0] e, input string name);
    rd_addr = a;
    sb_due.push_back(cyc + 1); sb_kind.push_back(0);
    sb_exp.push_back(e); sb_name.push_back(name);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sine[i] = 8'($rtoi(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * i / 256.0) + 0.5));
    end

    // Asynchronous reset before any clock edge; arm must be ignored while held.
    #2 rst = 1'b0;
    #1;
    chk("rst_async_busy", {7'b0, busy}, 8'h00);
    chk("rst_async_done", {7'b0, done}, 8'h00);
    chk("rst_async_rd",   rd_data,      8'h00);
    arm = 1'b1; drive(1, 8'h90);
    tick();
    chk("rst_arm_ignored", {7'b0, busy}, 8'h00);
    tick();
    arm = 1'b0; rst = 1'b1; drive(0, 8'h00);
    expect_st(0, 0, "idle");
    tick();

    // Ramp 0,1,2,... ; triggers on 0x80, mem[k] = 0x80+k.
    arm = 1'b1; drive(1, 8'h00); expect_st(1, 0, "ramp_arm"); tick(); arm = 1'b0;
    for (int i = 1; i <= 16'h17F; i++) begin
      drive(1, i[7:0]);
      if (i == 16'h080) expect_st(1, 0, "ramp_trig");
      if (i == 16'h17E) expect_st(1, 0, "ramp_not_early");
      if (i == 16'h17F) expect_st(0, 1, "ramp_done");
      tick();
    end
    drive(0, 8'h00);
    expect_rd(8'h10, 8'h90, "ramp_rd10"); tick();
    expect_rd(8'h00, 8'h80, "ramp_rd00"); tick();
    expect_rd(8'hFF, 8'h7F, "ramp_rdFF"); tick();

    // Flat-high signal must not trigger; 0x7F -> 0x80 does. arm in CAPTURE ignored.
    arm = 1'b1; drive(0, 8'h00); expect_st(1, 0, "rearm_from_done"); tick(); arm = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'hC0);
      if (i == 9) expect_st(1, 0, "flat_no_trig");
      tick();
    end
    drive(1, 8'h7F); tick();
    drive(1, 8'h80); expect_st(1, 0, "cross_trig"); tick();
    for (int k = 1; k < 256; k++) begin
      drive(1, 8'(k) ^ 8'h80);
      if (k == 50) begin
        arm = 1'b1;
        expect_st(1, 0, "arm_in_cap");
      end
      if (k == 254) expect_st(1, 0, "cap_not_early");
      if (k == 255) expect_st(0, 1, "cap_done");
      tick();
      arm = 1'b0;
    end
    drive(0, 8'h00);
    expect_rd(8'h00, 8'h80, "cross_rd00"); tick();
    expect_rd(8'h55, 8'hD5, "cross_rd55"); tick();
    expect_rd(8'hFF, 8'h7F, "cross_rdFF"); tick();

    // First sample never triggers; en=0 samples are invisible; 50% en duty.
    arm = 1'b1; drive(0, 8'h00); expect_st(1, 0, "rearm_gate"); tick(); arm = 1'b0;
    drive(1, 8'h90); tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, (i % 2) ? 8'hFF : 8'h00);
      if (i == 5) expect_st(1, 0, "gate_no_trig");
      tick();
    end
    drive(1, 8'h10); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, (i % 2) ? 8'h00 : 8'hFF);
      tick();
    end
    drive(1, 8'hA0); tick();
    for (int k = 1; k < 256; k++) begin
      drive(0, 8'h00);
      if (k == 255) expect_st(1, 0, "duty_not_early");
      tick();
      drive(1, 8'(8'hA0 + k));
      if (k == 8'h20) expect_rd(8'h20, 8'hA0, "rd_old_on_write");
      if (k == 255) expect_st(0, 1, "duty_done");
      tick();
    end
    drive(0, 8'h00);
    expect_rd(8'h00, 8'hA0, "duty_rd00"); tick();
    expect_rd(8'h20, 8'hC0, "duty_rd20"); tick();
    expect_rd(8'h60, 8'h00, "duty_rd60"); tick();
    expect_rd(8'hFF, 8'h9F, "duty_rdFF"); tick();

    // Reset after 100 captured samples.
    arm = 1'b1; drive(0, 8'h00); expect_st(1, 0, "arm_pre_rst"); tick(); arm = 1'b0;
    for (int i = 0; i <= 115; i++) begin
      drive(1, 8'(8'h70 + i));
      tick();
    end
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_busy", {7'b0, busy}, 8'h00);
    chk("rst_mid_done", {7'b0, done}, 8'h00);
    chk("rst_mid_rd",   rd_data,      8'h00);
    tick();
    rst = 1'b1; drive(0, 8'h00);
    expect_st(0, 0, "post_rst_idle");
    tick();

    // Sine source from phase 200: crossing at phase 0, mem[k] = sine[k].
    arm = 1'b1; drive(0, 8'h00); expect_st(1, 0, "arm_sine"); tick(); arm = 1'b0;
    for (int i = 0; i < 312; i++) begin
      drive(1, sine[(200 + i) % 256]);
      if (i == 56)  expect_st(1, 0, "sine_trig");
      if (i == 310) expect_st(1, 0, "sine_not_early");
      if (i == 311) expect_st(0, 1, "sine_done");
      tick();
    end
    drive(0, 8'h00);
    expect_rd(8'h00, 8'h80, "sine_rd00"); tick();
    expect_rd(8'h40, 8'hFF, "sine_rd40"); tick();
    expect_rd(8'hC0, 8'h01, "sine_rdC0"); tick();
    expect_rd(8'hFF, 8'h7D, "sine_rdFF"); tick();

    tick();
    tick();
    chk("sb_drain", 8'(sb_due.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sig_capture.md
# sig_capture

Triggered single-shot capture buffer that sits directly downstream of the sine generator. It watches the generated sample stream on cycles where the generator is enabled, and waits for a rising crossing of a programmable threshold. On that crossing it stores the next 2^A_WIDTH samples into an internal RAM. The stored waveform is then available on a synchronous read port for display or checking.

## Interface
- A_WIDTH, 8, capture RAM address width; depth = 2^A_WIDTH samples
- D_WIDTH, 8, sample width; matches generator output width
- clk  input  1  sole clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- en  input  1  sample valid; high on cycles where the generator advances (tie to generator en)
- din  input  D_WIDTH  sample from generator (dout1 or dout2)
- arm  input  1  single-cycle request to start a new capture
- thresh  input  D_WIDTH  trigger level, unsigned
- rd_addr  input  A_WIDTH  readback address
- rd_data  output  D_WIDTH  RAM contents at rd_addr, registered
- busy  output  1  high in ARMED or CAPTURE
- done  output  1  high in DONE; a complete capture is held in RAM

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- Reset (rst=0, async): state to IDLE; busy=0, done=0, rd_data=0, wr_ptr=0, prev_valid=0. RAM contents are not reset.
- IDLE or DONE with arm=1:
  - Next state is ARMED.
  - prev_valid and wr_ptr are cleared, and done drops.
  - RAM keeps its old data until it is overwritten.
- ARMED, arm=1: ignored. CAPTURE, arm=1: ignored (no restart).
- ARMED, en=1:
  - If prev_valid=1 and prev < thresh and din >= thresh (unsigned), the trigger fires.
  - On trigger: din is written to address 0, wr_ptr becomes 1, next state is CAPTURE.
  - prev is updated to din and prev_valid is set to 1 on every en cycle in ARMED.
- The first en sample after arming can never trigger, because there is no previous sample.
- en=0 cycles: no compare, no write, prev unchanged.
- din == thresh with prev < thresh counts as a crossing. prev >= thresh never triggers (falling or flat signal).
- CAPTURE, en=1:
  - din is written to mem[wr_ptr] and wr_ptr increments.
  - The write at address 2^A_WIDTH-1 is the last one; next state is DONE.
- wr_ptr is A_WIDTH bits wide and wraps to 0 on that final write. Exactly 2^A_WIDTH samples are stored, including the trigger sample.
- DONE: no writes; remains there until arm is asserted or reset.
- Read port:
  - rd_data <= mem[rd_addr] every clock, in all states.
  - A read and write to the same address in the same cycle returns the old data.
- busy = (state==ARMED or CAPTURE). done = (state==DONE). Both are registered state decodes with no combinational path from inputs.

## Timing
- arm sampled at edge N: busy=1 after edge N, done=0 after edge N.
- Trigger sample is at edge T: mem[0] is written at edge T, and the state is CAPTURE after T.
- With en continuously high, the last write happens at edge T+2^A_WIDTH-1. done=1 and busy=0 after that same edge.
- Capture spans 2^A_WIDTH en-cycles. Cycles with en=0 stretch it without gaps in the RAM.
- rd_data latency: 1 cycle from rd_addr.
- Reset asserted mid-CAPTURE:
  - Outputs go immediately to their reset values.
  - Partial RAM data remains but done stays 0.
  - A new arm is required.
- Throughput: one sample per clock when en=1 every cycle.

## Test plan
- Reset: rst=0 asynchronously mid-cycle -> busy=0, done=0, rd_data=0 without waiting for clk; arm ignored while rst=0.
- Ramp trigger:
  - Stimulus: A_WIDTH=8, thresh=0x80, din = 0,1,2,... with en=1, arm pulsed.
  - busy=1 next cycle.
  - Trigger fires on din=0x80; mem[k] = 0x80+k mod 256 for k=0..255.
  - done=1 exactly 256 en-cycles after trigger; readback rd_addr=0x10 gives rd_data=0x90 one cycle later.
- No false trigger: arm, then din held at 0xC0 with thresh=0x80 -> stays ARMED (busy=1, done=0). Drive din 0x7F then 0x80 -> triggers, mem[0]=0x80.
- First-sample rule and en gating:
  - Arm; the first en sample is 0x90 with thresh 0x80 -> no trigger.
  - en=0 cycles with din toggling 0x00/0xFF -> no trigger and no writes.
  - During CAPTURE, en duty 50% -> RAM contiguous; done only after 256 en-cycles.
- Arm handling:
  - arm re-pulsed during CAPTURE -> ignored; done arrives on schedule.
  - arm pulsed in DONE -> done=0 and busy=1 next cycle; a new capture overwrites from address 0.
- Reset mid-capture:
  - rst=0 after 100 captured samples -> IDLE, done=0.
  - Re-arm with a sine source (generator incr=1, thresh=0x80) -> done=1 after 256 samples.
  - Readback shows mem[0]>=0x80 and the previous stored sample <0x80 pattern; mem[64] is near 0xFF (peak).
